// File: rtl/morse_tx.sv
// Morse key-line transmitter: takes one ASCII character per valid/ready handshake and
// emits the timed on/off key line plus dot/dash/end-of-character symbol strobes.
module morse_tx #(
  parameter int unsigned UNIT_CYCLES = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ch_data,
  input  logic       ch_valid,
  output logic       ch_ready,
  output logic       key_out,
  output logic [1:0] sym_out,
  output logic       sym_valid,
  output logic       busy,
  output logic       bad_char
);

  // Handshake: a character transfers on a rising clk edge where ch_valid & ch_ready;
  // ch_data is captured on that edge and ch_ready drops in the following cycle.

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MARK     = 3'd1,
    S_EL_GAP   = 3'd2,
    S_CHAR_GAP = 3'd3,
    S_WORD_GAP = 3'd4
  } state_t;

  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_EOC  = 2'b11;

  localparam logic [30:0] CNT_1U = 31'(UNIT_CYCLES - 1);
  localparam logic [30:0] CNT_3U = 31'(3 * UNIT_CYCLES - 1);
  localparam logic [30:0] CNT_7U = 31'(7 * UNIT_CYCLES - 1);

  state_t      state_q;
  logic [30:0] cnt_q;
  logic [2:0]  idx_q;
  logic [2:0]  len_q;
  logic [4:0]  pat_q;
  logic        ready_q;
  logic        key_q;
  logic [1:0]  sym_q;
  logic        sym_valid_q;
  logic        busy_q;
  logic        bad_q;

  logic [7:0]  uc;
  logic [7:0]  lut;
  logic [2:0]  lut_len;
  logic [4:0]  lut_pat;
  logic        is_space;
  logic [4:0]  pat_rem;

  // Table entry is {length, pattern}; pattern bit i is element i (1 = dash). Length 0 = not a letter/digit.
  always_comb begin
    uc  = (ch_data >= 8'h61 && ch_data <= 8'h7A) ? ch_data - 8'h20 : ch_data;
    lut = 8'h00;
    case (uc)
      "A": lut = {3'd2, 5'b00010};
      "B": lut = {3'd4, 5'b00001};
      "C": lut = {3'd4, 5'b00101};
      "D": lut = {3'd3, 5'b00001};
      "E": lut = {3'd1, 5'b00000};
      "F": lut = {3'd4, 5'b00100};
      "G": lut = {3'd3, 5'b00011};
      "H": lut = {3'd4, 5'b00000};
      "I": lut = {3'd2, 5'b00000};
      "J": lut = {3'd4, 5'b01110};
      "K": lut = {3'd3, 5'b00101};
      "L": lut = {3'd4, 5'b00010};
      "M": lut = {3'd2, 5'b00011};
      "N": lut = {3'd2, 5'b00001};
      "O": lut = {3'd3, 5'b00111};
      "P": lut = {3'd4, 5'b00110};
      "Q": lut = {3'd4, 5'b01011};
      "R": lut = {3'd3, 5'b00010};
      "S": lut = {3'd3, 5'b00000};
      "T": lut = {3'd1, 5'b00001};
      "U": lut = {3'd3, 5'b00100};
      "V": lut = {3'd4, 5'b01000};
      "W": lut = {3'd3, 5'b00110};
      "X": lut = {3'd4, 5'b01001};
      "Y": lut = {3'd4, 5'b01101};
      "Z": lut = {3'd4, 5'b00011};
      "0": lut = {3'd5, 5'b11111};
      "1": lut = {3'd5, 5'b11110};
      "2": lut = {3'd5, 5'b11100};
      "3": lut = {3'd5, 5'b11000};
      "4": lut = {3'd5, 5'b10000};
      "5": lut = {3'd5, 5'b00000};
      "6": lut = {3'd5, 5'b00001};
      "7": lut = {3'd5, 5'b00011};
      "8": lut = {3'd5, 5'b00111};
      "9": lut = {3'd5, 5'b01111};
      default: lut = 8'h00;
    endcase
    lut_len  = lut[7:5];
    lut_pat  = lut[4:0];
    is_space = (ch_data == 8'h20);
  end

  // idx_q already points at the upcoming element while in EL_GAP.
  assign pat_rem = pat_q >> idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      pat_q       <= '0;
      ready_q     <= 1'b0;
      key_q       <= 1'b0;
      sym_q       <= 2'b00;
      sym_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      sym_valid_q <= 1'b0;
      sym_q       <= 2'b00;
      bad_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          key_q   <= 1'b0;
          if (ch_valid && ready_q) begin
            if (lut_len != 3'd0) begin
              state_q     <= S_MARK;
              len_q       <= lut_len;
              pat_q       <= lut_pat;
              idx_q       <= 3'd0;
              cnt_q       <= lut_pat[0] ? CNT_3U : CNT_1U;
              key_q       <= 1'b1;
              busy_q      <= 1'b1;
              ready_q     <= 1'b0;
              sym_valid_q <= 1'b1;
              sym_q       <= lut_pat[0] ? SYM_DASH : SYM_DOT;
            end else if (is_space) begin
              state_q <= S_WORD_GAP;
              cnt_q   <= CNT_7U;
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              bad_q <= 1'b1;
            end
          end
        end
        S_MARK: begin
          if (cnt_q != 31'd0) begin
            cnt_q <= cnt_q - 31'd1;
          end else if (idx_q == len_q - 3'd1) begin
            state_q     <= S_CHAR_GAP;
            cnt_q       <= CNT_3U;
            key_q       <= 1'b0;
            sym_valid_q <= 1'b1;
            sym_q       <= SYM_EOC;
          end else begin
            state_q <= S_EL_GAP;
            cnt_q   <= CNT_1U;
            key_q   <= 1'b0;
            idx_q   <= idx_q + 3'd1;
          end
        end
        S_EL_GAP: begin
          if (cnt_q != 31'd0) begin
            cnt_q <= cnt_q - 31'd1;
          end else begin
            state_q     <= S_MARK;
            cnt_q       <= pat_rem[0] ? CNT_3U : CNT_1U;
            key_q       <= 1'b1;
            sym_valid_q <= 1'b1;
            sym_q       <= pat_rem[0] ? SYM_DASH : SYM_DOT;
          end
        end
        S_CHAR_GAP, S_WORD_GAP: begin
          if (cnt_q != 31'd0) begin
            cnt_q <= cnt_q - 31'd1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          key_q   <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ch_ready  = ready_q;
  assign key_out   = key_q;
  assign sym_out   = sym_q;
  assign sym_valid = sym_valid_q;
  assign busy      = busy_q;
  assign bad_char  = bad_q;

endmodule

// File: tb/tb_morse_tx.sv
// Bench for morse_tx: three instances (1, 2 and 4 cycles per unit) driven one at a time,
// every output cycle compared against a trace built from Morse code strings.
module tb_morse_tx;

  // Output vector bit layout: {ready, busy, key, sym_valid, sym[1:0], bad}
  localparam logic [6:0] R    = 7'b1000000;
  localparam logic [6:0] BUSY = 7'b0100000;
  localparam logic [6:0] KEY  = 7'b0010000;
  localparam logic [6:0] SV   = 7'b0001000;
  localparam logic [6:0] DOT  = 7'b0000010;
  localparam logic [6:0] DASH = 7'b0000100;
  localparam logic [6:0] EOC  = 7'b0000110;
  localparam logic [6:0] BAD  = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ch_data = 8'h00;
  logic       ch_valid = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       chk_idle = 1'b0;

  logic       valid_w [3];
  logic       ready_w [3];
  logic       key_w   [3];
  logic [1:0] sym_w   [3];
  logic       sv_w    [3];
  logic       busy_w  [3];
  logic       bad_w   [3];
  logic [6:0] act;

  int tests = 0;
  int fails = 0;
  logic [6:0] exp_q[$];
  logic [6:0] tr_q[$];
  logic [6:0] exp_v;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign valid_w[g] = ch_valid && (sel == 2'(g));
    morse_tx #(.UNIT_CYCLES(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
      .clk      (clk),
      .rst      (rst),
      .ch_data  (ch_data),
      .ch_valid (valid_w[g]),
      .ch_ready (ready_w[g]),
      .key_out  (key_w[g]),
      .sym_out  (sym_w[g]),
      .sym_valid(sv_w[g]),
      .busy     (busy_w[g]),
      .bad_char (bad_w[g])
    );
  end

  assign act = {ready_w[sel], busy_w[sel], key_w[sel], sv_w[sel], sym_w[sel], bad_w[sel]};

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, a, e);
    end
  endtask

  function automatic int unit_of(input logic [1:0] s);
    return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
  endfunction

  function automatic string morse(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    case (u)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
      "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
      "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
      "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
      "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
      "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
      "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
      "8": return "---.."; "9": return "----.";
      8'h20: return " ";
      default: return "";
    endcase
  endfunction

  // Expected outputs for the cycles after an accept edge, ending with the first ready cycle.
  task automatic build(input logic [7:0] c, input int u);
    string s;
    byte   b;
    int    m;
    tr_q.delete();
    s = morse(c);
    if (s.len() == 0) begin
      tr_q.push_back(R | BAD);
    end else if (s == " ") begin
      repeat (7 * u) tr_q.push_back(BUSY);
      tr_q.push_back(R);
    end else begin
      for (int i = 0; i < s.len(); i++) begin
        b = s[i];
        m = (b == 8'h2D) ? 3 * u : u;
        for (int k = 0; k < m; k++)
          tr_q.push_back(BUSY | KEY | ((k == 0) ? (SV | ((b == 8'h2D) ? DASH : DOT)) : 7'b0));
        if (i < s.len() - 1) repeat (u) tr_q.push_back(BUSY);
      end
      for (int k = 0; k < 3 * u; k++) tr_q.push_back(BUSY | ((k == 0) ? (SV | EOC) : 7'b0));
      tr_q.push_back(R);
    end
  endtask

  // Called at a negedge; leaves at the negedge of the first cycle after the accept.
  task automatic send(input logic [7:0] c, input bit hold);
    int n;
    n = 0;
    while (!act[6] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!act[6]) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout at %0t: got ready=0 want ready=1", $time);
      ch_valid = 1'b0;
      return;
    end
    ch_data  = c;
    ch_valid = 1'b1;
    build(c, unit_of(sel));
    foreach (tr_q[i]) exp_q.push_back(tr_q[i]);
    @(negedge clk);
    if (!hold) ch_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout at %0t: got %0d pending want 0", $time, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic select(input logic [1:0] s);
    wait_drain();
    sel = s;
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      check("cycle", 32'(act), 32'(exp_v));
    end else if (chk_idle) begin
      check("idle", 32'(act), 32'(R));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog at %0t: got no finish want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int         cnt_busy, cnt_dash, r;
    logic [7:0] c;
    bit         h, hold_prev;

    // Pin the model against hand-derived traces.
    build("E", 4);
    check("model_E_len", tr_q.size(), 17);
    check("model_E_c1", 32'(tr_q[0]), 32'(BUSY | KEY | SV | DOT));
    check("model_E_c4", 32'(tr_q[3]), 32'(BUSY | KEY));
    check("model_E_c5", 32'(tr_q[4]), 32'(BUSY | SV | EOC));
    check("model_E_c17", 32'(tr_q[16]), 32'(R));
    build("a", 2);
    check("model_a_len", tr_q.size(), 17);
    check("model_a_c5", 32'(tr_q[4]), 32'(BUSY | KEY | SV | DASH));
    check("model_a_c11", 32'(tr_q[10]), 32'(BUSY | SV | EOC));
    build("0", 1);
    cnt_busy = 0;
    cnt_dash = 0;
    foreach (tr_q[i]) begin
      if ((tr_q[i] & BUSY) != 7'b0) cnt_busy++;
      if ((tr_q[i] & (SV | EOC)) == (SV | DASH)) cnt_dash++;
    end
    check("model_0_busy", cnt_busy, 22);
    check("model_0_dashes", cnt_dash, 5);
    build(8'h20, 1);
    check("model_space_len", tr_q.size(), 8);

    // Reset, then ready one cycle after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check("reset_outputs", 32'(act), 32'(7'b0));
    end
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check("ready_after_reset", 32'(act), 32'(R));
    end
    chk_idle = 1'b1;

    select(2'd2); send("E", 1'b0);
    select(2'd1); send("a", 1'b0);
    select(2'd0); send("0", 1'b0);
    select(2'd0); send("S", 1'b1); send(8'h20, 1'b0);
    select(2'd0); send("#", 1'b1); send("T", 1'b0);

    // Reset in the middle of the dash of 'T'.
    select(2'd2);
    send("T", 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_q.push_back(7'b0);
    repeat (10) exp_q.push_back(R);
    @(negedge clk);
    rst = 1'b0;
    wait_drain();

    hold_prev = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (!hold_prev) select(2'($urandom_range(0, 2)));
      r = $urandom_range(0, 9);
      if (r < 4)       c = 8'h41 + 8'($urandom_range(0, 25));
      else if (r < 6)  c = 8'h61 + 8'($urandom_range(0, 25));
      else if (r < 8)  c = 8'h30 + 8'($urandom_range(0, 9));
      else if (r == 8) c = 8'h20;
      else             c = 8'h21 + 8'($urandom_range(0, 14));
      h = (t < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      send(c, h);
      hold_prev = h;
      if (!h) repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    wait_drain();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
